// File: rtl/pio_pattern_sequencer_if.sv
// Bus bundle for the PIO pattern sequencer: host-side Avalon-MM slave port,
// PIO-side Avalon-MM master port and the interrupt line.
interface pio_pattern_sequencer_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        irq;

  // Sequencer's view.
  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata, irq
  );

  // System / host view.
  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata, irq
  );
endinterface

// File: rtl/pio_pattern_sequencer.sv
// Plays a host-programmed table of up to 8 bytes into a PIO, one single-cycle
// Avalon-MM write every INTERVAL clocks, optionally looping.
module pio_pattern_sequencer (
  input logic                    clk,
  input logic                    reset,
  pio_pattern_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        loop_q, loop_d;
  logic        irq_en_q, irq_en_d;
  logic [2:0]  length_q, length_d;
  logic [31:0] interval_q, interval_d;
  logic [7:0]  pattern_q [8];
  logic [7:0]  pattern_d [8];
  logic [7:0]  last_wd_q, last_wd_d;

  logic        wr_en;
  logic [31:0] period;

  assign wr_en  = bus.chipselect & ~bus.write_n;
  // An interval of 0 is treated as 1.
  assign period = (interval_q == 32'd0) ? 32'd1 : interval_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    loop_d     = loop_q;
    irq_en_d   = irq_en_q;
    length_d   = length_q;
    interval_d = interval_q;
    pattern_d  = pattern_q;
    last_wd_d  = last_wd_q;

    case (state_q)
      StIdle: ;
      StWrite: begin
        last_wd_d = pattern_q[idx_q];
        if (idx_q == length_q && !loop_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          // idx is free to wrap past 7 when LENGTH was lowered below it.
          idx_d   = (idx_q == length_q) ? 3'd0 : idx_q + 3'd1;
          cnt_d   = period - 32'd2;
          state_d = (period == 32'd1) ? StWrite : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 32'd0) state_d = StWrite;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = StIdle;
    endcase

    // Host writes come last so a CTRL write overrides the FSM transition.
    if (wr_en) begin
      case (bus.address)
        4'd0: begin
          loop_d   = bus.writedata[1];
          irq_en_d = bus.writedata[3];
          if (bus.writedata[2]) done_d = 1'b0;
          if (bus.writedata[0]) begin
            state_d = StWrite;
            idx_d   = 3'd0;
            done_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        4'd1: length_d   = bus.writedata[2:0];
        4'd2: interval_d = bus.writedata;
        default: begin
          if (bus.address[3]) pattern_d[bus.address[2:0]] = bus.writedata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      cnt_q      <= 32'd0;
      done_q     <= 1'b0;
      loop_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      length_q   <= 3'd0;
      interval_q <= 32'd0;
      pattern_q  <= '{default: 8'd0};
      last_wd_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      loop_q     <= loop_d;
      irq_en_q   <= irq_en_d;
      length_q   <= length_d;
      interval_q <= interval_d;
      pattern_q  <= pattern_d;
      last_wd_q  <= last_wd_d;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      4'd0: bus.readdata[3:0] = {irq_en_q, done_q, loop_q, state_q != StIdle};
      4'd1: bus.readdata[2:0] = length_q;
      4'd2: bus.readdata      = interval_q;
      4'd3: bus.readdata[5:0] = {state_q, 1'b0, idx_q};
      default: begin
        if (bus.address[3]) bus.readdata[7:0] = pattern_q[bus.address[2:0]];
      end
    endcase
  end

  // Data bus keeps the last byte sent; only the strobes qualify it.
  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = (state_q == StWrite);
  assign bus.pio_write_n    = (state_q != StWrite);
  assign bus.pio_writedata  = {24'd0, (state_q == StWrite) ? pattern_q[idx_q] : last_wd_q};
  assign bus.irq            = done_q & irq_en_q;

endmodule

// File: doc/pio_pattern_sequencer.md
# pio_pattern_sequencer

Avalon-MM controlled sequencer that drives an 8-bit PIO output port through a programmed pattern table. A host (Nios II) loads up to 8 patterns, a step interval, a length and loop mode. The block then acts as the sole Avalon-MM master of the PIO's s1 slave, issuing single-cycle writes at exact cycle intervals with no CPU involvement. It sits between the system interconnect (slave side) and the output PIO (master side).

## Interface
Parameters:
- none; all widths fixed.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  4  slave register address.
- chipselect  in  1  slave select.
- write_n  in  1  slave write strobe, active low.
- writedata  in  32  slave write data.
- readdata  out  32  slave read data; combinational, zero wait states.
- pio_address  out  2  master address to PIO; constant 0.
- pio_chipselect  out  1  master select to PIO.
- pio_write_n  out  1  master write strobe to PIO, active low.
- pio_writedata  out  32  master write data; bits 31:8 always 0.
- irq  out  1  level interrupt: done AND irq_en.

## Operation
Register map (slave writes need chipselect=1 and write_n=0):
- 0 CTRL: bit0 run, bit1 loop, bit2 done, bit3 irq_en.
  - Writing bit0=1 starts or restarts at index 0 and clears done.
  - Writing bit0=0 stops the sequencer.
  - Writing bit2=1 clears done.
  - Readback: bit0 is 1 when state is not IDLE.
- 1 LENGTH: bits 2:0 hold last index (steps-1).
- 2 INTERVAL: 32-bit step period N in clk cycles; 0 behaves as 1.
- 3 STATUS: read-only; bits 2:0 current index, bits 5:4 state encoding.
- 8..15 PATTERN[0..7]: bits 7:0 are R/W.
- Unmapped addresses read 0 and ignore writes.

State machine (IDLE=0, WRITE=1, WAIT=2):
- IDLE: pio_chipselect=0, pio_write_n=1. Start moves to WRITE with idx=0.
- WRITE (exactly one cycle):
  - Drive pio_chipselect=1, pio_write_n=0, pio_writedata={24'b0, PATTERN[idx]}.
  - If idx==LENGTH: with loop=0, set done and go to IDLE after the write; with loop=1, set idx=0.
  - Otherwise idx increments.
  - Next state is WAIT with counter=N-2 if N>=2; if N==1, go straight to WRITE.
- WAIT: count down; at 0 go to WRITE.
- Stop (CTRL bit0=0 write):
  - Next state is IDLE, no further PIO writes.
  - A write cycle already asserted in the same cycle completes.
- Start while running restarts from idx 0. Counter is reloaded on the next WRITE.
- Writes to PATTERN, LENGTH or INTERVAL while running are allowed.
  - A PATTERN entry takes effect when that entry is next sent.
  - INTERVAL takes effect at the next WRITE.
  - If LENGTH is lowered below the current idx, idx wraps at 7, then counts up to LENGTH.
- pio_writedata holds the last value driven; it is only qualified by the strobes.

## Timing
- Reset values:
  - readdata reflects reset registers (CTRL=0, LENGTH=0, INTERVAL=0, PATTERN=0).
  - pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0, irq=0.
  - state IDLE, idx 0, done 0.
- Reset mid-sequence returns everything to reset values on the next edge and issues no PIO write.
- Start latency: CTRL write sampled at edge T puts the first WRITE in cycle T+1. PIO out_port updates at the end of T+1.
- Period: successive WRITE cycles are exactly N cycles apart, for N from 1 to 2^32-1.
- done (and irq if enabled) rises on the edge that ends the final WRITE. It stays high until cleared or restarted.
- A slave write to CTRL and a state transition in the same cycle: the slave write wins.

## Test plan
- Reset, then read all registers and check PIO outputs -> all 0, pio_write_n=1, irq=0.
- Load PATTERN[0..3]=0x01,0x02,0x04,0x08; LENGTH=3; INTERVAL=5; loop=0; run at T -> PIO writes in cycles T+1, T+6, T+11, T+16 with the 4 values in order; done=1 after T+16; no further writes.
- Same setup with loop=1, INTERVAL=0 -> back-to-back writes 01,02,04,08,01,… every cycle; STATUS idx cycles 1,2,3,0.
- Looping with N=10; write run=0 in a WAIT cycle -> no further pio_chipselect; readback run=0; out value unchanged.
- irq_en=1, sequence completes -> irq=1; write CTRL bit2=1 -> irq=0 next cycle. Then pulse reset mid-WAIT -> all outputs at reset values and no write issued.
